fir_tap_sequencer: RTL and testbench

Controller that sequences the coefficient memory (h, 16 x 32-bit) and sample memory (x, 64 x 32-bit) for the DSP58 FIR MAC datapath. For each output index n it walks the taps k = 0..NUM_TAPS-1, issuing h_addr = k and x_addr = n-k. It emits accumulator control aligned to the memory and MAC pipeline latencies. It sits between the top-level start/done control and the memory, MAC and output capture logic.

---
 rtl/fir_tap_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: walks taps k=0..NUM_TAPS-1 for each output n, drives h/x memory addresses and MAC control.
// Latency: acc_* flags MEM_LATENCY cycles after R_en; y_valid a further MAC_LATENCY cycles later.
// Backpressure: hold freezes address issue (bubbles flow down the pipeline); DRAIN ignores hold.
module fir_tap_sequencer #(
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_ADDR_WIDTH = 6,
  parameter int MEM_LATENCY     = 1,
  parameter int MAC_LATENCY     = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       hold,
  output logic [ADDR_WIDTH-1:0]      h_addr,
  output logic [DATA_ADDR_WIDTH-1:0] x_addr,
  output logic                       R_en,
  output logic                       acc_en,
  output logic                       acc_clr,
  output logic                       x_zero,
  output logic                       y_valid,
  output logic [DATA_ADDR_WIDTH-1:0] y_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int NUM_TAPS     = 1 << ADDR_WIDTH;
  localparam int NUM_SAMPLES  = 1 << DATA_ADDR_WIDTH;
  localparam int DRAIN_CYCLES = MEM_LATENCY + MAC_LATENCY;
  localparam int CW           = $clog2(DRAIN_CYCLES + 1);

  localparam logic [ADDR_WIDTH-1:0]      K_LAST   = ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic [DATA_ADDR_WIDTH-1:0] N_LAST   = DATA_ADDR_WIDTH'(NUM_SAMPLES - 1);
  localparam logic [CW-1:0]              CNT_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      k_q, k_d;
  logic [DATA_ADDR_WIDTH-1:0] n_q, n_d;
  logic [CW-1:0]              cnt_q, cnt_d;

  logic                       issue;
  logic                       n_ge_k;
  logic [DATA_ADDR_WIDTH-1:0] k_ext;

  // Issue-side pipeline (memory read latency) and result-side pipeline (MAC latency).
  logic                       mem_vld_q   [MEM_LATENCY];
  logic                       mem_first_q [MEM_LATENCY];
  logic                       mem_zero_q  [MEM_LATENCY];
  logic                       mem_last_q  [MEM_LATENCY];
  logic [DATA_ADDR_WIDTH-1:0] mem_n_q     [MEM_LATENCY];
  logic                       mac_vld_q   [MAC_LATENCY];
  logic [DATA_ADDR_WIDTH-1:0] mac_n_q     [MAC_LATENCY];

  // Control state and tap/sample counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: one tap per un-held RUN cycle, then a fixed drain for in-flight work.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = '0;
          n_d     = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (!hold) begin
          issue = 1'b1;
          if (k_q == K_LAST) begin
            k_d = '0;
            if (n_q == N_LAST) begin
              n_d     = '0;
              cnt_d   = '0;
              state_d = S_DRAIN;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address generation: taps reaching before x[0] read address 0 and are flagged as zero.
  always_comb begin
    k_ext  = DATA_ADDR_WIDTH'(k_q);
    n_ge_k = (n_q >= k_ext);
    h_addr = k_q;
    x_addr = n_ge_k ? (n_q - k_ext) : '0;
    R_en   = issue;
  end

  // Flag pipelines; every flag is qualified by issue so bubbles travel as all-zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        mem_vld_q[i]   <= 1'b0;
        mem_first_q[i] <= 1'b0;
        mem_zero_q[i]  <= 1'b0;
        mem_last_q[i]  <= 1'b0;
        mem_n_q[i]     <= '0;
      end
      for (int i = 0; i < MAC_LATENCY; i++) begin
        mac_vld_q[i] <= 1'b0;
        mac_n_q[i]   <= '0;
      end
    end else begin
      mem_vld_q[0]   <= issue;
      mem_first_q[0] <= issue && (k_q == '0);
      mem_zero_q[0]  <= issue && !n_ge_k;
      mem_last_q[0]  <= issue && (k_q == K_LAST);
      mem_n_q[0]     <= issue ? n_q : '0;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        mem_vld_q[i]   <= mem_vld_q[i-1];
        mem_first_q[i] <= mem_first_q[i-1];
        mem_zero_q[i]  <= mem_zero_q[i-1];
        mem_last_q[i]  <= mem_last_q[i-1];
        mem_n_q[i]     <= mem_n_q[i-1];
      end
      mac_vld_q[0] <= mem_vld_q[MEM_LATENCY-1] && mem_last_q[MEM_LATENCY-1];
      mac_n_q[0]   <= mem_last_q[MEM_LATENCY-1] ? mem_n_q[MEM_LATENCY-1] : '0;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        mac_vld_q[i] <= mac_vld_q[i-1];
        mac_n_q[i]   <= mac_n_q[i-1];
      end
    end
  end

  // Data-aligned MAC controls and final-result strobe.
  always_comb begin
    acc_en  = mem_vld_q[MEM_LATENCY-1];
    acc_clr = mem_vld_q[MEM_LATENCY-1] && mem_first_q[MEM_LATENCY-1];
    x_zero  = mem_zero_q[MEM_LATENCY-1];
    y_valid = mac_vld_q[MAC_LATENCY-1];
    y_idx   = mac_n_q[MAC_LATENCY-1];
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
module tb_fir_tap_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, hold;
  logic [3:0] h_addr;
  logic [5:0] x_addr, y_idx;
  logic       R_en, acc_en, acc_clr, x_zero, y_valid, busy, done;

  int errors = 0;
  int checks = 0;

  fir_tap_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .h_addr(h_addr), .x_addr(x_addr), .R_en(R_en), .acc_en(acc_en),
    .acc_clr(acc_clr), .x_zero(x_zero), .y_valid(y_valid), .y_idx(y_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [22:0] all_out;
  assign all_out = {h_addr, x_addr, R_en, acc_en, acc_clr, x_zero, y_valid, y_idx, busy, done};

  // Observations recorded over one pass (cycle 0 = the cycle start is sampled)
  logic [3:0] h_at1;
  logic [5:0] x_at1;
  logic       ren_at1, en_at2, clr_at2;
  int  yv_cnt, yv_first, yv_last, yidx_err, ycyc_err, yv_after_rst;
  int  done_cyc, done_cnt, busy_err;
  int  issue_cnt, en_cnt, clr_cnt, clr_err, hseq_err, xaddr_err, xz_err, xz_late;
  logic [5:0] n3_x [16];
  logic       n3_z [16];
  int  hold_ren, hold_addr_chg;
  logic [3:0] hold_h;
  logic [5:0] hold_x;
  logic [6:0] en_win;
  logic       post_rst_zero;

  task automatic drive_pass(input int hold_at, input int hold_len, input int start_again_at,
                            input int rst_at, input int max_cyc);
    int busy_end, en, ek, exp_y;
    logic [5:0] ex;
    yv_cnt = 0; yv_first = 0; yv_last = 0; yidx_err = 0; ycyc_err = 0; yv_after_rst = 0;
    done_cyc = 0; done_cnt = 0; busy_err = 0;
    issue_cnt = 0; en_cnt = 0; clr_cnt = 0; clr_err = 0; hseq_err = 0; xaddr_err = 0;
    xz_err = 0; xz_late = 0; hold_ren = 0; hold_addr_chg = 0; en_win = '0;
    post_rst_zero = 1'b0; hold_h = '0; hold_x = '0;
    for (int i = 0; i < 16; i++) begin n3_x[i] = 6'h3f; n3_z[i] = 1'bx; end
    busy_end = (rst_at > 0) ? rst_at : 1028 + hold_len;
    @(posedge clk); #1;
    start = 1'b1; hold = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= max_cyc; c++) begin
      #1;
      start = (c == start_again_at);
      hold  = (hold_len > 0) && (c >= hold_at) && (c < hold_at + hold_len);
      rst_n = !(rst_at > 0 && c == rst_at);
      @(negedge clk);
      if (c == 1) begin ren_at1 = R_en; h_at1 = h_addr; x_at1 = x_addr; end
      if (c == 2) begin en_at2 = acc_en; clr_at2 = acc_clr; end
      if (rst_at > 0 && c == rst_at + 1) post_rst_zero = (all_out == '0);
      if (busy !== (c <= busy_end)) busy_err++;
      if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
      if (hold_len > 0) begin
        if (c == hold_at) begin hold_h = h_addr; hold_x = x_addr; end
        if (c >= hold_at && c < hold_at + hold_len && R_en) hold_ren++;
        if (c > hold_at && c <= hold_at + hold_len && (h_addr !== hold_h || x_addr !== hold_x))
          hold_addr_chg++;
        if (c >= hold_at && c <= hold_at + 6) en_win[c - hold_at] = acc_en;
      end
      if (R_en) begin
        en = issue_cnt / 16; ek = issue_cnt % 16;
        ex = (en >= ek) ? 6'(en - ek) : 6'd0;
        if (h_addr !== 4'(ek)) hseq_err++;
        if (x_addr !== ex) xaddr_err++;
        if (en == 3) n3_x[ek] = x_addr;
        issue_cnt++;
      end
      if (acc_en) begin
        en = en_cnt / 16; ek = en_cnt % 16;
        if (x_zero !== (en < ek)) xz_err++;
        if (en == 3) n3_z[ek] = x_zero;
        if (en >= 15 && x_zero) xz_late++;
        if (acc_clr !== (ek == 0)) clr_err++;
        if (acc_clr) clr_cnt++;
        en_cnt++;
      end else if (acc_clr || x_zero) begin
        clr_err++;
      end
      if (y_valid) begin
        exp_y = 16 * yv_cnt + 20;
        if (hold_len > 0 && 16 * yv_cnt + 16 >= hold_at) exp_y += hold_len;
        if (c != exp_y) ycyc_err++;
        if (y_idx !== 6'(yv_cnt)) yidx_err++;
        if (yv_cnt == 0) yv_first = c;
        yv_last = c;
        if (rst_at > 0 && c > rst_at) yv_after_rst++;
        yv_cnt++;
      end
      @(posedge clk);
    end
    #1;
    start = 1'b0; hold = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", all_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (all_out !== '0) begin errors++; $display("FAIL idle_outputs got=%h want=0", all_out); end
  endtask

  task automatic test_basic_pass();
    drive_pass(0, 0, 0, 0, 1040);
    checks++; if (ren_at1 !== 1'b1) begin errors++; $display("FAIL c1_ren got=%b want=1", ren_at1); end
    checks++; if (h_at1 !== 4'd0 || x_at1 !== 6'd0) begin errors++; $display("FAIL c1_addr got h=%0d x=%0d want 0 0", h_at1, x_at1); end
    checks++; if (en_at2 !== 1'b1 || clr_at2 !== 1'b1) begin errors++; $display("FAIL c2_acc got en=%b clr=%b want 1 1", en_at2, clr_at2); end
    checks++; if (yv_first != 20) begin errors++; $display("FAIL first_yvalid got=%0d want=20", yv_first); end
    checks++; if (yv_cnt != 64) begin errors++; $display("FAIL yvalid_count got=%0d want=64", yv_cnt); end
    checks++; if (yv_last != 1028) begin errors++; $display("FAIL last_yvalid got=%0d want=1028", yv_last); end
    checks++; if (ycyc_err != 0) begin errors++; $display("FAIL yvalid_timing got=%0d bad want=0", ycyc_err); end
    checks++; if (yidx_err != 0) begin errors++; $display("FAIL y_idx_seq got=%0d bad want=0", yidx_err); end
    checks++; if (done_cyc != 1029 || done_cnt != 1) begin errors++; $display("FAIL done got cyc=%0d cnt=%0d want 1029 1", done_cyc, done_cnt); end
    checks++; if (busy_err != 0) begin errors++; $display("FAIL busy_window got=%0d bad want=0", busy_err); end
    checks++; if (en_cnt != 1024 || clr_cnt != 64) begin errors++; $display("FAIL acc_counts got en=%0d clr=%0d want 1024 64", en_cnt, clr_cnt); end
    checks++; if (clr_err != 0) begin errors++; $display("FAIL acc_clr_pattern got=%0d bad want=0", clr_err); end
    checks++; if (hseq_err != 0) begin errors++; $display("FAIL h_addr_seq got=%0d bad want=0", hseq_err); end
  endtask

  task automatic test_zero_pad();
    logic [5:0] want_x;
    drive_pass(0, 0, 0, 0, 1040);
    for (int k = 0; k < 16; k++) begin
      want_x = (k <= 3) ? 6'(3 - k) : 6'd0;
      checks++;
      if (n3_x[k] !== want_x || n3_z[k] !== (k > 3)) begin
        errors++;
        $display("FAIL n3_tap%0d got x=%0d z=%b want x=%0d z=%b", k, n3_x[k], n3_z[k], want_x, (k > 3));
      end
    end
    checks++; if (xaddr_err != 0) begin errors++; $display("FAIL x_addr_all got=%0d bad want=0", xaddr_err); end
    checks++; if (xz_err != 0) begin errors++; $display("FAIL x_zero_all got=%0d bad want=0", xz_err); end
    checks++; if (xz_late != 0) begin errors++; $display("FAIL x_zero_n15plus got=%0d want=0", xz_late); end
  endtask

  task automatic test_hold();
    drive_pass(100, 5, 0, 0, 1045);
    checks++; if (hold_ren != 0) begin errors++; $display("FAIL hold_ren got=%0d want=0", hold_ren); end
    checks++; if (hold_addr_chg != 0) begin errors++; $display("FAIL hold_addr_frozen got=%0d changes want=0", hold_addr_chg); end
    checks++; if (en_win !== 7'b1000001) begin errors++; $display("FAIL hold_acc_gap got=%b want=1000001", en_win); end
    checks++; if (ycyc_err != 0 || yv_cnt != 64) begin errors++; $display("FAIL hold_yvalid got bad=%0d cnt=%0d want 0 64", ycyc_err, yv_cnt); end
    checks++; if (done_cyc != 1034) begin errors++; $display("FAIL hold_done got=%0d want=1034", done_cyc); end
    checks++; if (busy_err != 0 || xaddr_err != 0) begin errors++; $display("FAIL hold_busy_addr got busy=%0d addr=%0d want 0 0", busy_err, xaddr_err); end
  endtask

  task automatic test_mid_reset();
    drive_pass(0, 0, 0, 500, 1040);
    checks++; if (post_rst_zero !== 1'b1) begin errors++; $display("FAIL mid_reset_outputs got=%b want=1", post_rst_zero); end
    checks++; if (yv_after_rst != 0) begin errors++; $display("FAIL mid_reset_yvalid got=%0d want=0", yv_after_rst); end
    checks++; if (done_cnt != 0 || busy_err != 0) begin errors++; $display("FAIL mid_reset_idle got done=%0d busy_bad=%0d want 0 0", done_cnt, busy_err); end
    drive_pass(0, 0, 0, 0, 1040);
    checks++; if (ren_at1 !== 1'b1 || h_at1 !== 4'd0 || x_at1 !== 6'd0) begin errors++; $display("FAIL restart_first got ren=%b h=%0d x=%0d want 1 0 0", ren_at1, h_at1, x_at1); end
    checks++; if (yv_cnt != 64 || done_cyc != 1029) begin errors++; $display("FAIL restart_pass got y=%0d done=%0d want 64 1029", yv_cnt, done_cyc); end
  endtask

  task automatic test_start_while_busy();
    drive_pass(0, 0, 300, 0, 1040);
    checks++; if (yv_cnt != 64 || ycyc_err != 0) begin errors++; $display("FAIL busy_start_y got cnt=%0d bad=%0d want 64 0", yv_cnt, ycyc_err); end
    checks++; if (done_cyc != 1029 || done_cnt != 1) begin errors++; $display("FAIL busy_start_done got cyc=%0d cnt=%0d want 1029 1", done_cyc, done_cnt); end
    checks++; if (hseq_err != 0 || issue_cnt != 1024) begin errors++; $display("FAIL busy_start_issue got bad=%0d n=%0d want 0 1024", hseq_err, issue_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hold = 1'b0;
    test_reset();
    test_basic_pass();
    test_zero_pad();
    test_hold();
    test_mid_reset();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
